// File: rtl/weight_mem_pkg.sv
// Shared types and saturating arithmetic for the weight memory block.
package weight_mem_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_UPDATE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UPD_WR = 2'b01,
    ST_CLR    = 2'b10
  } state_e;

  // Adds two sign-extended w-bit values one bit wider than w and clamps to the w-bit range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return 32'(sum);
  endfunction

endpackage

// File: rtl/weight_mem_if.sv
// Request/response bus between a requester (master) and weight_mem (slave).
interface weight_mem_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_op;
  logic [ADDR_W-1:0]        req_addr;
  logic signed [DATA_W-1:0] req_data;
  logic                     rsp_valid;
  logic signed [DATA_W-1:0] rsp_data;
  logic                     busy;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/weight_sat_add.sv
// Combinational saturating adder for DATA_W-bit signed weights.
module weight_sat_add
  import weight_mem_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = DATA_W'(sat_add(32'(a), 32'(b), DATA_W));

endmodule

// File: rtl/weight_mem.sv
// Signed weight store with READ/WRITE/UPDATE (saturating add) ops.
// Optional bulk CLEAR is built when WEIGHT_MEM_CLEAR_EN is defined.
module weight_mem
  import weight_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  weight_mem_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e                   state;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        upd_addr_p1;
  logic signed [DATA_W-1:0] upd_old_p1;
  logic signed [DATA_W-1:0] upd_delta_p1;
  logic                     upd_ok_p1;
  logic signed [DATA_W-1:0] upd_sum;
  logic signed [DATA_W-1:0] rd_val;
  logic                     addr_ok;
  logic                     accept;
  op_e                      op;

`ifdef WEIGHT_MEM_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt;
`endif

  assign op            = op_e'(bus.req_op);
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  // Out-of-range indices (non-power-of-two DEPTH) read as zero and are never written.
  assign addr_ok       = ({1'b0, bus.req_addr} < DEPTH_L);
  assign rd_val        = addr_ok ? mem[bus.req_addr] : '0;

  weight_sat_add #(.DATA_W(DATA_W)) u_sat_add (
    .a(upd_old_p1),
    .b(upd_delta_p1),
    .y(upd_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      upd_addr_p1   <= '0;
      upd_old_p1    <= '0;
      upd_delta_p1  <= '0;
      upd_ok_p1     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef WEIGHT_MEM_CLEAR_EN
      clr_cnt <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        // Stage p0: accept and either complete or latch operands
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_READ: begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= rd_val;
              end
              OP_WRITE: begin
                if (addr_ok) begin
                  mem[bus.req_addr] <= bus.req_data;
                end
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= addr_ok ? bus.req_data : '0;
              end
              OP_UPDATE: begin
                upd_addr_p1  <= bus.req_addr;
                upd_old_p1   <= rd_val;
                upd_delta_p1 <= bus.req_data;
                upd_ok_p1    <= addr_ok;
                state        <= ST_UPD_WR;
              end
              OP_CLEAR: begin
`ifdef WEIGHT_MEM_CLEAR_EN
                clr_cnt <= '0;
                state   <= ST_CLR;
`endif
              end
              default: ;
            endcase
          end
        end
        // Stage p1: write back the saturated sum
        ST_UPD_WR: begin
          if (upd_ok_p1) begin
            mem[upd_addr_p1] <= upd_sum;
          end
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= upd_ok_p1 ? upd_sum : '0;
          state         <= ST_IDLE;
        end
`ifdef WEIGHT_MEM_CLEAR_EN
        ST_CLR: begin
          mem[clr_cnt] <= '0;
          if (clr_cnt == CLR_LAST) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= '0;
            state         <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_mem.md
WEIGHT_MEM -- requirements
Module: weight_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, weight width in bits (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 16, number of weight entries; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-007 SHALL have port req_op  input  2  00 READ, 01 WRITE, 10 UPDATE, 11 CLEAR.
REQ-008 SHALL have port req_addr  input  ADDR_W  entry index.
REQ-009 SHALL have port req_data  input  DATA_W  write data (WRITE) or signed reward delta (UPDATE).
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have port rsp_data  output  DATA_W  response value, held until the next response.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, UPD_WR, CLR; req_ready = (state == IDLE).
REQ-014 READ accepted at edge N SHALL give rsp_valid=1, rsp_data=mem[addr] in cycle N+1; no memory change.
REQ-015 WRITE accepted at edge N SHALL write mem[addr]=req_data at edge N and give rsp_valid=1, rsp_data=req_data in cycle N+1.
REQ-016 UPDATE accepted at edge N SHALL latch mem[addr], addr, delta and enter UPD_WR; at edge N+1 write sat(old+delta), return to IDLE, rsp_valid=1 with new value in cycle N+2.
REQ-017 Saturating add SHALL compute in DATA_W+1 bits and clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 req_addr >= DEPTH (non-power-of-two DEPTH) SHALL be accepted, leave memory unchanged, respond with rsp_data=0.
REQ-019 Requests presented while req_ready=0 SHALL be neither accepted nor lost by the block; requester holds them.
REQ-020 rsp_valid SHALL be high for exactly one cycle per completed op, never for a non-accepted request.
REQ-021 Back-to-back READ/WRITE SHALL sustain one accept per cycle; READ after WRITE to same addr SHALL return the new value.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, all mem entries=0, rsp_valid=0, rsp_data=0, busy=0, clear counter=0.
REQ-023 Reset during UPD_WR or CLR SHALL abort the op with no response after release.
REQ-024 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro WEIGHT_MEM_CLEAR_EN defined: CLEAR accepted at edge N enters CLR, zeroes entry k at edge N+1+k for k=0..DEPTH-1, returns to IDLE, rsp_valid=1 with rsp_data=0 in cycle N+DEPTH+1.
REQ-026 Macro undefined: op 11 SHALL be accepted in one cycle with no memory change and no response; CLR state and counter SHALL not be synthesised.

Structure
REQ-027 Shared package weight_mem_pkg SHALL hold the op encoding enum, FSM state enum, and the saturating-add function.
REQ-028 Saturating adder SHALL be the sub-module weight_sat_add (parameter DATA_W, combinational); storage stays in weight_mem.

Verification
REQ-029 WRITE addr 3 data 0x5A, then READ addr 3 -> responses 0x5A, 0x5A on consecutive cycles.
REQ-030 WRITE addr 7 0x7C, UPDATE addr 7 delta 0x10 -> rsp 0x7F (positive clamp), req_ready low one cycle.
REQ-031 WRITE addr 2 0x85, UPDATE addr 2 delta 0xF0 -> rsp 0x80 (negative clamp); UPDATE addr 2 delta 0x05 -> rsp 0x85.
REQ-032 CLEAR_EN defined: fill all 16 with 0xFF, CLEAR -> busy 16 cycles, rsp 0x00, all READs return 0x00.
REQ-033 Assert rst_n low mid-UPDATE on addr 4 (old 0x20, delta 0x01) -> no rsp, READ addr 4 returns 0x00.
REQ-034 req_valid held high with READ during UPD_WR -> READ accepted on the cycle req_ready returns, single rsp.
